seq_shift_add_mult: RTL and testbench

SEQ_SHIFT_ADD_MULT -- requirements
Module: seq_shift_add_mult

---
 rtl/mult_pkg.sv | 18 +
 rtl/mult_addsub.sv | 41 ++++
 rtl/seq_shift_add_mult.sv | 149 ++++++++++++++
 tb/tb_seq_shift_add_mult.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared FSM state type and width limits for the sequential multiplier
//
// Purpose: common declarations imported by seq_shift_add_mult.
//   state_t    : IDLE / RUN / DONE controller states
//   WIDTH_MIN  : smallest legal operand width
//   WIDTH_MAX  : largest legal operand width
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/mult_addsub.sv
// rtl/mult_addsub.sv - WIDTH-bit adder/subtractor with carry-out and sign-extension bit
//
// Purpose: combinational add (or subtract, signed build only) of the running
// partial product and the multiplicand.
// Optional feature macro: SEQ_MULT_SIGNED_EN (adds i_sub and o_sext).
// Ports:
//   i_a     in  WIDTH  partial product upper half
//   i_b     in  WIDTH  multiplicand
//   i_sub   in  1      subtract i_b instead of adding (signed build only)
//   o_sum   out WIDTH  low WIDTH bits of the result
//   o_carry out 1      unsigned carry-out
//   o_sext  out 1      bit WIDTH of the sign-extended result (signed build only)
module mult_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic             i_sub,
  output logic             o_sext,
`endif
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

`ifdef SEQ_MULT_SIGNED_EN
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_u;

  // a - b == a + ~b + 1
  assign w_b = i_sub ? ~i_b : i_b;
  assign w_u = {1'b0, i_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, i_sub};
  assign o_sum   = w_u[WIDTH-1:0];
  assign o_carry = w_u[WIDTH];
  // Bit WIDTH of the sign-extended sum: both sign bits plus the carry into that position.
  assign o_sext  = i_a[WIDTH-1] ^ w_b[WIDTH-1] ^ w_u[WIDTH];
`else
  assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b};
`endif

endmodule

// File: rtl/seq_shift_add_mult.sv
// rtl/seq_shift_add_mult.sv - sequential shift-and-add multiplier, one bit per clock
//
// Purpose: multiplies two WIDTH-bit operands in WIDTH RUN cycles, producing a
// 2*WIDTH-bit product in {HI_FF, LO_FF}.
// Optional feature macro: SEQ_MULT_SIGNED_EN (two's-complement mode, port signed_op).
// Ports:
//   clock        in  1      rising-edge clock
//   reset        in  1      asynchronous active-high reset
//   start        in  1      start request, honoured in IDLE or DONE
//   multiplicand in  WIDTH  operand A
//   multiplier   in  WIDTH  operand B
//   signed_op    in  1      two's-complement request (signed build only)
//   busy         out 1      high while iterating
//   done         out 1      one-cycle completion pulse
//   HI_FF        out WIDTH  upper product half
//   LO_FF        out WIDTH  lower product half
module seq_shift_add_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI_FF,
  output logic [WIDTH-1:0] LO_FF
);

  localparam int CW = $clog2(WIDTH + 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("seq_shift_add_mult: WIDTH out of range");
  end

  state_t           r_state;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_mcand;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;

  logic             w_last;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic [WIDTH-1:0] w_new;
  logic             w_msb;

  assign w_last = (r_cnt == CW'(1));

`ifdef SEQ_MULT_SIGNED_EN
  logic r_signed;
  logic w_sub;
  logic w_sext;

  // Signed mode: the multiplier's MSB carries weight -2^(WIDTH-1), so the last step subtracts.
  assign w_sub = r_signed & w_last;

  mult_addsub #(.WIDTH(WIDTH)) u_addsub (
    .i_a     (r_hi),
    .i_b     (r_mcand),
    .i_sub   (w_sub),
    .o_sext  (w_sext),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  always_comb begin
    w_new = r_lo[0] ? w_sum : r_hi;
    if (r_signed) begin
      // Arithmetic shift: keep the sign of the (possibly updated) partial product.
      w_msb = r_lo[0] ? w_sext : r_hi[WIDTH-1];
    end else begin
      w_msb = r_lo[0] & w_carry;
    end
  end
`else
  mult_addsub #(.WIDTH(WIDTH)) u_addsub (
    .i_a     (r_hi),
    .i_b     (r_mcand),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  always_comb begin
    w_new = r_lo[0] ? w_sum : r_hi;
    w_msb = r_lo[0] & w_carry;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_hi    <= '0;
      r_lo    <= '0;
      r_mcand <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
      r_signed <= 1'b0;
`endif
    end else begin
      case (r_state)
        RUN: begin
          // {HI,LO} <= {msb, new_hi, LO[W-1:1]}: one combined right shift of the product register.
          r_hi  <= {w_msb, w_new[WIDTH-1:1]};
          r_lo  <= {w_new[0], r_lo[WIDTH-1:1]};
          r_cnt <= r_cnt - CW'(1);
          if (w_last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept start; DONE otherwise falls back to IDLE.
          r_done <= 1'b0;
          if (start) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_hi    <= '0;
            r_lo    <= multiplier;
            r_mcand <= multiplicand;
            r_cnt   <= CW'(WIDTH);
`ifdef SEQ_MULT_SIGNED_EN
            r_signed <= signed_op;
`endif
          end else begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign HI_FF = r_hi;
  assign LO_FF = r_lo;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// tb/tb_seq_shift_add_mult.sv - self-checking bench for seq_shift_add_mult (WIDTH=8)
module tb_seq_shift_add_mult;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] mcand;
  logic [7:0] mplier;
  logic       sgn;
  logic       busy;
  logic       done;
  logic [7:0] hi;
  logic [7:0] lo;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_shift_add_mult #(.WIDTH(8)) dut (
    .clock        (clk),
    .reset        (rst),
    .start        (start),
    .multiplicand (mcand),
    .multiplier   (mplier),
`ifdef SEQ_MULT_SIGNED_EN
    .signed_op    (sgn),
`endif
    .busy         (busy),
    .done         (done),
    .HI_FF        (hi),
    .LO_FF        (lo)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Counts busy cycles from the current negedge until busy drops (bounded).
  task automatic wait_busy(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic do_op(input string nm, input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic [15:0] exp);
    int cyc;
    @(negedge clk);
    mcand = a; mplier = b; sgn = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_busy(cyc);
    chk({nm, " cycles"}, cyc, 8);
    chk({nm, " done"}, done, 1'b1);
    chk({nm, " product"}, {hi, lo}, exp);
    @(negedge clk);
    chk({nm, " done_pulse"}, done, 1'b0);
    chk({nm, " hold"}, {hi, lo}, exp);
  endtask

  initial begin
    int cyc;

    vecs.push_back('{a: 8'd13,  b: 8'd11,  s: 1'b0, exp: 16'h008F});
    vecs.push_back('{a: 8'd255, b: 8'd255, s: 1'b0, exp: 16'hFE01});
    vecs.push_back('{a: 8'h00,  b: 8'hA5,  s: 1'b0, exp: 16'h0000});
    vecs.push_back('{a: 8'hA5,  b: 8'h00,  s: 1'b0, exp: 16'h0000});
    vecs.push_back('{a: 8'd200, b: 8'd2,   s: 1'b0, exp: 16'h0190});
    vecs.push_back('{a: 8'd128, b: 8'd2,   s: 1'b0, exp: 16'h0100});
    vecs.push_back('{a: 8'd1,   b: 8'd1,   s: 1'b0, exp: 16'h0001});
`ifdef SEQ_MULT_SIGNED_EN
    vecs.push_back('{a: 8'hFD,  b: 8'h05,  s: 1'b1, exp: 16'hFFF1});
    vecs.push_back('{a: 8'h80,  b: 8'h80,  s: 1'b1, exp: 16'h4000});
    vecs.push_back('{a: 8'h7F,  b: 8'hFF,  s: 1'b1, exp: 16'hFF81});
    vecs.push_back('{a: 8'd200, b: 8'd2,   s: 1'b0, exp: 16'h0190});
    vecs.push_back('{a: 8'hFF,  b: 8'hFF,  s: 1'b0, exp: 16'hFE01});
`endif

    rst = 1'b1; start = 1'b1; mcand = 8'd5; mplier = 8'd5; sgn = 1'b0;
    repeat (3) @(negedge clk);
    // start held during reset must be ignored
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset product", {hi, lo}, 16'h0000);
    start = 1'b0;
    rst = 1'b0;

    foreach (vecs[i]) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp);
    end

    // start and operand changes while running are ignored
    @(negedge clk);
    mcand = 8'd13; mplier = 8'd11; sgn = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      start = (cyc == 3);
      mcand = ~mcand; mplier = mplier + 8'd37;
      @(negedge clk);
    end
    start = 1'b0;
    chk("midrun cycles", cyc, 8);
    chk("midrun done", done, 1'b1);
    chk("midrun product", {hi, lo}, 16'h008F);

    // back-to-back: start held in DONE launches the next product with no IDLE cycle
    @(negedge clk);
    mcand = 8'd9; mplier = 8'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_busy(cyc);
    chk("b2b first product", {hi, lo}, 16'h0051);
    chk("b2b first done", done, 1'b1);
    mcand = 8'd7; mplier = 8'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b immediate busy", busy, 1'b1);
    chk("b2b done cleared", done, 1'b0);
    wait_busy(cyc);
    chk("b2b cycles", cyc, 8);
    chk("b2b second product", {hi, lo}, 16'h002A);

    // asynchronous reset in the middle of a run
    @(negedge clk);
    @(negedge clk);
    mcand = 8'd13; mplier = 8'd11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre-reset busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async reset busy", busy, 1'b0);
    chk("async reset done", done, 1'b0);
    chk("async reset product", {hi, lo}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    chk("post-reset idle", busy, 1'b0);
    do_op("after reset 3x3", 8'd3, 8'd3, 1'b0, 16'h0009);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
